snes_serializer: RTL and testbench
==================================

// Module: snes_serializer
// PURPOSE
//  Drives the SNES console controller port from the merged 12-bit button word
//  (button_press from assign_button) under console-driven latch/clock.
//  Snapshots buttons on latch, shifts 16 bits out MSB-last on snes_data.
//  Console pins are asynchronous to clk; the block synchronizes and edge-detects them.
// PARAMETERS
//  NUM_BUTTONS  12  live button bits, bit0 = B ... bit11 = R (snes_pkg order)
//  FRAME_BITS   16  bits per frame; bits NUM_BUTTONS..FRAME_BITS-1 = "not pressed"
//  SYNC_STAGES  2   flops in each console-pin synchronizer (>=2)
// PORTS
//  clk          in   1   system clock (2.08 MHz OSCH)
//  reset        in   1   asynchronous, active-high reset
//  buttons      in   12  pressed=1, synchronous to clk
//  snes_latch   in   1   console latch pin, async, active-high
//  snes_clk     in   1   console clock pin, async, idles high
//  snes_data    out  1   controller data pin, active-low (pressed=0)
//  frame_done   out  1   one-clk pulse after bit FRAME_BITS-1 has been shifted past
//  overrun      out  1   one-clk pulse when latch rises while state=SHIFT
// BEHAVIOUR
//  Reset: state=IDLE, shreg=all 1s, bit_cnt=0, snes_data=1, frame_done=0, overrun=0,
//   synchronizer flops reset to latch=0, clk=1 (no false edge out of reset).
//  Sync: latch_s/clk_s = last stage of SYNC_STAGES chain; rise/fall from prev-cycle copy.
//   Edge pulses are 1 clk wide, delayed SYNC_STAGES+1 clk from pin edge.
//  FSM states IDLE, LATCH, SHIFT, DONE:
//   IDLE : latch_rise -> LATCH. snes_data=1.
//   LATCH: every clk while latch_s=1: shreg <= {4'b1111, ~buttons} (live reload;
//          last value before fall is frame content); bit_cnt<=0; snes_data=shreg[0].
//          latch_fall -> SHIFT (bit0 already on snes_data, no clock edge consumed).
//   SHIFT: on clk_rise: shreg <= {1'b0, shreg[15:1]}, bit_cnt++;
//          when bit_cnt==FRAME_BITS-1 at clk_rise -> DONE, frame_done=1 that cycle.
//          latch_rise -> LATCH, overrun=1 (frame abandoned, new snapshot).
//          clk_fall ignored (console samples on falling edge).
//   DONE : snes_data=0 (line low after frame, matches genuine pad); latch_rise -> LATCH.
//  snes_data is registered: equals shreg[0] in LATCH/SHIFT, 1 in IDLE, 0 in DONE.
//  Extra clk_rise in DONE/IDLE: no effect. clk_rise while latch_s=1: ignored (latch wins).
//  latch_rise and clk_rise same cycle: latch wins. Simultaneous latch_fall & clk_rise: go
//   SHIFT without shifting (bit0 held a full console clock).
//  bit_cnt width $clog2(FRAME_BITS); saturates, never wraps past FRAME_BITS-1.
//  Reset mid-frame: immediate return to reset values; next latch_rise starts cleanly.
//  buttons changing during SHIFT do not affect the frame in progress.
// STRUCTURE
//  snes_pkg: typedef enum logic[1:0] {IDLE,LATCH,SHIFT,DONE} snes_state_t;
//   localparams NUM_BUTTONS, FRAME_BITS, button index constants (BTN_B..BTN_R).
//  Sub-module snes_sync_edge (one instance per console pin): SYNC_STAGES flop chain,
//   reset value param, outputs level, rise, fall.
//  Top: FSM, 16-bit shift register, bit counter, output register.
// TESTING
//  1 Reset, no console activity -> snes_data=1, frame_done=0, overrun=0 for 1000 clks.
//  2 buttons=12'h001 (B), 12us latch then 16 console clocks at 6us period -> sampled
//    on falls: bit0=0, bits1..15=1; frame_done pulses once; snes_data=0 afterwards.
//  3 buttons=12'hA5A -> sampled bits0..11 = ~12'hA5A LSB-first, bits12..15=1.
//  4 buttons toggled to 12'hFFF mid-SHIFT -> current frame unchanged; next frame all 0 in
//    bits0..11.
//  5 latch reasserted after 5 clocks -> overrun pulse, new frame restarts at bit0, no
//    frame_done for abandoned frame.
//  6 reset asserted at bit 7 -> snes_data=1 within same clk, next latch gives full frame.

Source files
------------

// File: rtl/snes_pkg.sv
// Shared types and constants for the SNES controller-port serializer.
// Button indices follow the order the console shifts them out.
`timescale 1ns/1ps
package snes_pkg;

    localparam int unsigned NUM_BUTTONS = 12;
    localparam int unsigned FRAME_BITS  = 16;

    localparam int unsigned BTN_B      = 0;
    localparam int unsigned BTN_Y      = 1;
    localparam int unsigned BTN_SELECT = 2;
    localparam int unsigned BTN_START  = 3;
    localparam int unsigned BTN_UP     = 4;
    localparam int unsigned BTN_DOWN   = 5;
    localparam int unsigned BTN_LEFT   = 6;
    localparam int unsigned BTN_RIGHT  = 7;
    localparam int unsigned BTN_A      = 8;
    localparam int unsigned BTN_X      = 9;
    localparam int unsigned BTN_L      = 10;
    localparam int unsigned BTN_R      = 11;

    typedef enum logic [1:0] {
        IDLE,
        LATCH,
        SHIFT,
        DONE
    } snes_state_t;

endpackage

// File: rtl/snes_sync_edge.sv
// Synchronizes one asynchronous console pin and derives single-cycle edge pulses.
// The extra flop past the synchronizer holds the previous level for edge detection.
`timescale 1ns/1ps
module snes_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          RESET_VAL   = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES:0] chain_q;

    // Resetting to the idle level keeps a false edge from appearing out of reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            chain_q <= {(SYNC_STAGES + 1){RESET_VAL}};
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-1:0], pin_i};
        end
    end

    always_comb begin
        level_o = chain_q[SYNC_STAGES-1];
        rise_o  = chain_q[SYNC_STAGES-1] & ~chain_q[SYNC_STAGES];
        fall_o  = ~chain_q[SYNC_STAGES-1] & chain_q[SYNC_STAGES];
    end

endmodule

// File: rtl/snes_serializer.sv
// Controller side of the SNES port: snapshots the button word on console latch and
// shifts it out active-low, one bit per console clock rising edge.
`timescale 1ns/1ps
module snes_serializer #(
    parameter int unsigned NUM_BUTTONS = snes_pkg::NUM_BUTTONS,
    parameter int unsigned FRAME_BITS  = snes_pkg::FRAME_BITS,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] buttons,
    input  logic                   snes_latch,
    input  logic                   snes_clk,
    output logic                   snes_data,
    output logic                   frame_done,
    output logic                   overrun
);

    import snes_pkg::*;

    localparam int unsigned CNT_W = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

    logic latch_s, latch_rise, latch_fall;
    logic clk_s, clk_rise, clk_fall;

    snes_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_latch_sync (
        .clk_i   (clk),
        .reset_i (reset),
        .pin_i   (snes_latch),
        .level_o (latch_s),
        .rise_o  (latch_rise),
        .fall_o  (latch_fall)
    );

    snes_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_clk_sync (
        .clk_i   (clk),
        .reset_i (reset),
        .pin_i   (snes_clk),
        .level_o (clk_s),
        .rise_o  (clk_rise),
        .fall_o  (clk_fall)
    );

    // The console samples on the falling edge, so only the rising edge matters here.
    logic unused_clk;
    assign unused_clk = clk_s ^ clk_fall;

    // Bits beyond the live buttons always read as "not pressed".
    logic [FRAME_BITS-1:0] snapshot;
    assign snapshot = {{(FRAME_BITS - NUM_BUTTONS){1'b1}}, ~buttons};

    snes_state_t           state_q;
    logic [FRAME_BITS-1:0] shreg_q;
    logic [CNT_W-1:0]      bit_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shreg_q    <= '1;
            bit_cnt_q  <= '0;
            snes_data  <= 1'b1;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            // A new latch always wins, abandoning any frame still being shifted.
            if (latch_rise) begin
                state_q   <= LATCH;
                shreg_q   <= snapshot;
                bit_cnt_q <= '0;
                snes_data <= snapshot[0];
                overrun   <= (state_q == SHIFT);
            end else begin
                unique case (state_q)
                    IDLE: begin
                        snes_data <= 1'b1;
                    end
                    LATCH: begin
                        if (latch_s) begin
                            shreg_q   <= snapshot;
                            bit_cnt_q <= '0;
                            snes_data <= snapshot[0];
                        end else if (latch_fall) begin
                            state_q <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (clk_rise) begin
                            shreg_q <= {1'b0, shreg_q[FRAME_BITS-1:1]};
                            if (bit_cnt_q == LAST_BIT) begin
                                state_q    <= DONE;
                                frame_done <= 1'b1;
                                snes_data  <= 1'b0;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                                snes_data <= shreg_q[1];
                            end
                        end
                    end
                    DONE: begin
                        snes_data <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_snes_serializer.sv
// Bench for snes_serializer: drives console latch/clock pins asynchronously to clk and
// compares the bits sampled on console clock falls against the expected frame.
`timescale 1ns/1ps
module tb_snes_serializer;

    localparam int CLK_HALF = 240;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] buttons = '0;
    logic        snes_latch = 1'b0;
    logic        snes_clk = 1'b1;
    logic        snes_data;
    logic        frame_done;
    logic        overrun;

    int checks = 0;
    int failures = 0;
    int done_pulses = 0;
    int ovr_pulses = 0;

    snes_serializer dut (
        .clk        (clk),
        .reset      (reset),
        .buttons    (buttons),
        .snes_latch (snes_latch),
        .snes_clk   (snes_clk),
        .snes_data  (snes_data),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #(CLK_HALF) clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) done_pulses++;
        if (overrun === 1'b1) ovr_pulses++;
    end

    typedef struct {
        logic [11:0] btn;
        int          nclk;
        logic [15:0] exp_bits;
        int          exp_done;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // Reference: a frame is the inverted button word, upper bits idle high, LSB first.
    function automatic logic [15:0] model_frame(input logic [11:0] b);
        return 16'hFFFF ^ {4'h0, b};
    endfunction

    // One console transaction; all delays are multiples of 120 ns after a 7 ns offset,
    // so pin changes and samples never coincide with a rising clk edge.
    task automatic console_frame(input logic [11:0] b, input int nclk, input int half,
                                 input int latch_w, input int chg_at, input logic [11:0] chg_b,
                                 output logic [15:0] got, output int dn, output int ov);
        int d0, o0;
        @(negedge clk);
        #7;
        d0 = done_pulses;
        o0 = ovr_pulses;
        buttons = b;
        got = '1;
        snes_latch = 1'b1;
        #(latch_w);
        snes_latch = 1'b0;
        #(half);
        for (int k = 0; k < nclk; k++) begin
            if (k == chg_at) buttons = chg_b;
            if (k < 16) got[k] = snes_data;
            snes_clk = 1'b0;
            #(half);
            snes_clk = 1'b1;
            #(half);
        end
        #(1920);
        dn = done_pulses - d0;
        ov = ovr_pulses - o0;
    endtask

    initial begin
        logic [15:0] got;
        logic [11:0] b;
        int dn, ov, bad;

        vecs[0] = '{12'h001, 16, 16'hFFFE, 1};
        vecs[1] = '{12'hA5A, 16, 16'hF5A5, 1};
        vecs[2] = '{12'h000, 16, 16'hFFFF, 1};
        vecs[3] = '{12'hFFF, 16, 16'hF000, 1};
        vecs[4] = '{12'h800, 20, 16'hF7FF, 1};
        vecs[5] = '{12'h555, 16, 16'hFAAA, 1};

        #1000;
        check("reset_data", {31'b0, snes_data}, 32'd1);
        check("reset_done", {31'b0, frame_done}, 32'd0);
        check("reset_overrun", {31'b0, overrun}, 32'd0);
        reset = 1'b0;

        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (snes_data !== 1'b1 || frame_done !== 1'b0 || overrun !== 1'b0) bad++;
        end
        check("idle_quiet_bad_cycles", bad, 0);

        foreach (vecs[i]) begin
            console_frame(vecs[i].btn, vecs[i].nclk, 3000, 12000, -1, 12'h0, got, dn, ov);
            check($sformatf("vec%0d_bits", i), {16'b0, got}, {16'b0, vecs[i].exp_bits});
            check($sformatf("vec%0d_done", i), dn, vecs[i].exp_done);
            check($sformatf("vec%0d_overrun", i), ov, 0);
            check($sformatf("vec%0d_data_after", i), {31'b0, snes_data}, 32'd0);
        end

        // Buttons change mid-frame: frame in progress keeps its snapshot.
        console_frame(12'h0F0, 16, 3000, 12000, 6, 12'hFFF, got, dn, ov);
        check("midshift_bits", {16'b0, got}, {16'b0, model_frame(12'h0F0)});
        console_frame(12'hFFF, 16, 3000, 12000, -1, 12'h0, got, dn, ov);
        check("next_frame_bits", {16'b0, got}, 32'h0000F000);

        // Latch reasserted after 5 console clocks abandons the frame.
        console_frame(12'h3C3, 5, 3000, 12000, -1, 12'h0, got, dn, ov);
        check("abort_partial_bits", {27'b0, got[4:0]}, {27'b0, model_frame(12'h3C3) & 16'h1F});
        check("abort_no_done", dn, 0);
        console_frame(12'h1A7, 16, 3000, 12000, -1, 12'h0, got, dn, ov);
        check("overrun_pulse", ov, 1);
        check("restart_bits", {16'b0, got}, {16'b0, model_frame(12'h1A7)});
        check("restart_done", dn, 1);

        // Reset at bit 7: output returns high immediately, next frame is clean.
        console_frame(12'h0AA, 7, 3000, 12000, -1, 12'h0, got, dn, ov);
        reset = 1'b1;
        #1;
        check("midreset_data", {31'b0, snes_data}, 32'd1);
        check("midreset_done", {31'b0, frame_done}, 32'd0);
        #(1199);
        reset = 1'b0;
        console_frame(12'h6E1, 16, 3000, 12000, -1, 12'h0, got, dn, ov);
        check("postreset_bits", {16'b0, got}, {16'b0, model_frame(12'h6E1)});
        check("postreset_done", dn, 1);
        check("postreset_overrun", ov, 0);

        // Randomized frames and console timing against the reference.
        for (int i = 0; i < 20; i++) begin
            b = 12'($urandom);
            console_frame(b, 16, 120 * $urandom_range(16, 40), 120 * $urandom_range(20, 100),
                          -1, 12'h0, got, dn, ov);
            check($sformatf("rand%0d_bits_btn%h", i, b), {16'b0, got}, {16'b0, model_frame(b)});
            check($sformatf("rand%0d_done", i), dn, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
